// File: rtl/rvm_mem_arbiter.sv
// Two-port round-robin arbiter sharing one SRAM-style memory port, with a burst limit.
// Latency: grant is registered (1-cycle arbitration); the request path through the mux is combinational.
// Backpressure: m_stall holds the current grant and its count; a waiting port sees stall=1.
module rvm_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        s0_c_en,
  input  logic        s0_w_en,
  input  logic [3:0]  s0_b_en,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  output logic [31:0] s0_rdata,
  output logic        s0_stall,
  output logic        s0_error,
  input  logic        s1_c_en,
  input  logic        s1_w_en,
  input  logic [3:0]  s1_b_en,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  output logic [31:0] s1_rdata,
  output logic        s1_stall,
  output logic        s1_error,
  output logic        m_c_en,
  output logic        m_w_en,
  output logic [3:0]  m_b_en,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_stall,
  input  logic        m_error,
  output logic [1:0]  gnt
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_oth_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_last;
  logic          w_last_nxt;
  logic          w_g0;
  logic          w_g1;
  logic          w_own_req;
  logic          w_oth_req;
  logic          w_own_idx;

  assign w_g0        = (r_state == ST_GNT0);
  assign w_g1        = (r_state == ST_GNT1);
  assign w_own_idx   = w_g1;
  assign w_own_req   = w_g1 ? s1_c_en : s0_c_en;
  assign w_oth_req   = w_g1 ? s0_c_en : s1_c_en;
  assign w_oth_state = w_g1 ? ST_GNT0 : ST_GNT1;
  // Burst count saturates so a lone requester never wraps back to a low count.
  assign w_cnt_inc   = (r_cnt == C_LAST) ? r_cnt : r_cnt + CW'(1);

  // Grant state, burst count and last-served port; reset favours port 0 (last=1).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: switch only at a completion boundary or when the grantee goes idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (s0_c_en && s1_c_en) begin
          w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        end else if (s0_c_en) begin
          w_state_nxt = ST_GNT0;
        end else if (s1_c_en) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!w_own_req) begin
          w_state_nxt = w_oth_req ? w_oth_state : ST_IDLE;
          w_cnt_nxt   = '0;
          w_last_nxt  = w_own_idx;
        end else if (!m_stall) begin
          if (w_oth_req && (r_cnt == C_LAST)) begin
            w_state_nxt = w_oth_state;
            w_cnt_nxt   = '0;
            w_last_nxt  = w_own_idx;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Downstream mux and upstream responses; IDLE drives the memory port to all zeros.
  always_comb begin
    m_c_en  = 1'b0;
    m_w_en  = 1'b0;
    m_b_en  = 4'h0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (w_g0) begin
      m_c_en  = s0_c_en;
      m_w_en  = s0_w_en;
      m_b_en  = s0_b_en;
      m_addr  = s0_addr;
      m_wdata = s0_wdata;
    end else if (w_g1) begin
      m_c_en  = s1_c_en;
      m_w_en  = s1_w_en;
      m_b_en  = s1_b_en;
      m_addr  = s1_addr;
      m_wdata = s1_wdata;
    end
  end

  assign gnt      = {w_g1, w_g0};
  assign s0_stall = s0_c_en & ~(w_g0 & ~m_stall);
  assign s1_stall = s1_c_en & ~(w_g1 & ~m_stall);
  assign s0_error = w_g0 & m_error;
  assign s1_error = w_g1 & m_error;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Directed bench for rvm_mem_arbiter: cycle table plus stall and async-reset sequences.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Every cycle of the table checks grant, mux fields and both ports' responses.
module tb_rvm_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        s0_c_en, s0_w_en, s1_c_en, s1_w_en;
  logic [3:0]  s0_b_en, s1_b_en;
  logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_stall, s0_error, s1_stall, s1_error;
  logic        m_c_en, m_w_en;
  logic [3:0]  m_b_en;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_stall, m_error;
  logic [1:0]  gnt;

  int n_chk;
  int n_fail;

  rvm_mem_arbiter #(.MAX_BURST(4)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .s0_c_en(s0_c_en), .s0_w_en(s0_w_en), .s0_b_en(s0_b_en), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_rdata(s0_rdata), .s0_stall(s0_stall), .s0_error(s0_error),
    .s1_c_en(s1_c_en), .s1_w_en(s1_w_en), .s1_b_en(s1_b_en), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_rdata(s1_rdata), .s1_stall(s1_stall), .s1_error(s1_error),
    .m_c_en(m_c_en), .m_w_en(m_w_en), .m_b_en(m_b_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_stall(m_stall), .m_error(m_error), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        s0c, s0w, s1c, s1w, mst, merr;
    logic [1:0]  gnt;
    logic        mcen, mwen;
    logic [31:0] maddr;
    logic        s0st, s1st, s0er, s1er;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //           s0c s0w s1c s1w mst merr gnt   mcen mwen maddr         s0st s1st s0er s1er
    tv[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0};
    tv[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,32'h100,    1'b0,1'b0,1'b0,1'b0};
    tv[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,32'h100,    1'b0,1'b0,1'b0,1'b0};
    tv[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h0,      1'b0,1'b1,1'b0,1'b0};
    tv[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0,32'h200,    1'b0,1'b0,1'b0,1'b0};
    tv[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,32'h200,    1'b0,1'b0,1'b0,1'b0};
    tv[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h0,      1'b1,1'b1,1'b0,1'b0};
    tv[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b1,32'h100,    1'b0,1'b1,1'b0,1'b0};
    tv[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b1,32'h100,    1'b0,1'b1,1'b0,1'b0};
    tv[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,32'h100,    1'b0,1'b1,1'b0,1'b0};
    tv[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,32'h100,    1'b0,1'b1,1'b0,1'b0};
    tv[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0,32'h200,    1'b1,1'b0,1'b0,1'b0};
    tv[12] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b10,1'b1,1'b1,32'h200,    1'b1,1'b0,1'b0,1'b0};
    tv[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,1'b1,1'b0,32'h200,    1'b1,1'b0,1'b0,1'b1};
    tv[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0,32'h200,    1'b1,1'b0,1'b0,1'b0};
    tv[15] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,32'h100,    1'b0,1'b1,1'b0,1'b0};
    tv[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,32'h100,    1'b0,1'b0,1'b0,1'b0};
    tv[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,1'b0};

    rst_n    = 1'b0;
    s0_c_en  = 1'b0; s0_w_en = 1'b0; s0_b_en = 4'h3; s0_addr = 32'h100; s0_wdata = 32'h1111_1111;
    s1_c_en  = 1'b0; s1_w_en = 1'b0; s1_b_en = 4'hC; s1_addr = 32'h200; s1_wdata = 32'h2222_2222;
    m_rdata  = 32'h0; m_stall = 1'b0; m_error = 1'b0;

    #2;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset m_c_en", 32'(m_c_en), 32'h0);
    chk("reset m_addr", m_addr, 32'h0);
    chk("reset m_wdata", m_wdata, 32'h0);
    chk("reset m_b_en", 32'(m_b_en), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      logic [31:0] exp_wdata;
      logic [3:0]  exp_ben;
      s0_c_en = tv[k].s0c; s0_w_en = tv[k].s0w;
      s1_c_en = tv[k].s1c; s1_w_en = tv[k].s1w;
      m_stall = tv[k].mst; m_error = tv[k].merr;
      m_rdata = 32'hDEAD_0000 + 32'(k);
      exp_wdata = (tv[k].gnt == 2'b01) ? 32'h1111_1111 : (tv[k].gnt == 2'b10) ? 32'h2222_2222 : 32'h0;
      exp_ben   = (tv[k].gnt == 2'b01) ? 4'h3 : (tv[k].gnt == 2'b10) ? 4'hC : 4'h0;
      @(negedge clk);
      chk($sformatf("v%0d gnt", k), 32'(gnt), 32'(tv[k].gnt));
      chk($sformatf("v%0d m_c_en", k), 32'(m_c_en), 32'(tv[k].mcen));
      chk($sformatf("v%0d m_w_en", k), 32'(m_w_en), 32'(tv[k].mwen));
      chk($sformatf("v%0d m_addr", k), m_addr, tv[k].maddr);
      chk($sformatf("v%0d m_wdata", k), m_wdata, exp_wdata);
      chk($sformatf("v%0d m_b_en", k), 32'(m_b_en), 32'(exp_ben));
      chk($sformatf("v%0d s0_stall", k), 32'(s0_stall), 32'(tv[k].s0st));
      chk($sformatf("v%0d s1_stall", k), 32'(s1_stall), 32'(tv[k].s1st));
      chk($sformatf("v%0d s0_error", k), 32'(s0_error), 32'(tv[k].s0er));
      chk($sformatf("v%0d s1_error", k), 32'(s1_error), 32'(tv[k].s1er));
      chk($sformatf("v%0d s0_rdata", k), s0_rdata, 32'hDEAD_0000 + 32'(k));
      chk($sformatf("v%0d s1_rdata", k), s1_rdata, 32'hDEAD_0000 + 32'(k));
      next_cycle();
    end

    // Port 0 write held by a downstream stall while port 1 waits.
    s0_c_en = 1'b1; s0_w_en = 1'b1; s1_c_en = 1'b0; m_stall = 1'b1; m_error = 1'b0;
    @(negedge clk);
    chk("stall idle gnt", 32'(gnt), 32'h0);
    chk("stall idle s0_stall", 32'(s0_stall), 32'h1);
    next_cycle();
    s1_c_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall c%0d gnt", c), 32'(gnt), 32'h1);
      chk($sformatf("stall c%0d s0_stall", c), 32'(s0_stall), 32'h1);
      chk($sformatf("stall c%0d s1_stall", c), 32'(s1_stall), 32'h1);
      chk($sformatf("stall c%0d m_wdata", c), m_wdata, 32'h1111_1111);
      chk($sformatf("stall c%0d m_b_en", c), 32'(m_b_en), 32'h3);
      chk($sformatf("stall c%0d m_w_en", c), 32'(m_w_en), 32'h1);
      next_cycle();
    end
    m_stall = 1'b0;
    @(negedge clk);
    chk("stall done gnt", 32'(gnt), 32'h1);
    chk("stall done s0_stall", 32'(s0_stall), 32'h0);
    chk("stall done s1_stall", 32'(s1_stall), 32'h1);
    next_cycle();
    s0_c_en = 1'b0; s0_w_en = 1'b0;
    @(negedge clk);
    chk("handover gnt", 32'(gnt), 32'h1);
    chk("handover m_c_en", 32'(m_c_en), 32'h0);
    next_cycle();

    // Asynchronous reset while port 1 is stalled with port 0 waiting.
    s0_c_en = 1'b1; m_stall = 1'b1;
    @(negedge clk);
    chk("pre-reset gnt", 32'(gnt), 32'h2);
    chk("pre-reset m_c_en", 32'(m_c_en), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset gnt", 32'(gnt), 32'h0);
    chk("async reset m_c_en", 32'(m_c_en), 32'h0);
    chk("async reset m_addr", m_addr, 32'h0);
    chk("async reset s0_stall", 32'(s0_stall), 32'h1);
    chk("async reset s1_stall", 32'(s1_stall), 32'h1);
    next_cycle();
    rst_n = 1'b1; m_stall = 1'b0;
    @(negedge clk);
    chk("post-reset idle gnt", 32'(gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("post-reset first gnt", 32'(gnt), 32'h1);
    chk("post-reset m_addr", m_addr, 32'h100);
    chk("post-reset s0_stall", 32'(s0_stall), 32'h0);
    chk("post-reset s1_stall", 32'(s1_stall), 32'h1);
    next_cycle();

    s0_c_en = 1'b0; s1_c_en = 1'b0;
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
